title_writer: RTL and testbench

TITLE_WRITER -- requirements
Module: title_writer

---
 rtl/title_writer.sv | 111 +++++++++++
 tb/tb_title_writer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/title_writer.sv
// title_writer: assembles an ASCII title line from a byte stream into a shadow
// buffer, then commits it to the registered titles output on a frame pulse.
module title_writer #(
  parameter int unsigned CHARS = 10,
  parameter logic [7:0]  PAD   = 8'h20
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               frame,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [8*CHARS-1:0] titles,
  output logic               title_upd,
  output logic               title_trunc
);

  localparam int unsigned IDX_W = $clog2(CHARS + 1);

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state;
  logic [7:0]       shadow [CHARS];
  logic [IDX_W-1:0] idx;
  logic             trunc_flag;

  logic             accept_c;
  logic             is_term_c;
  logic [7:0]       mapped_c;

  // Fold lowercase to uppercase; anything outside the printable 0x20-0x5F range becomes '?'.
  function automatic logic [7:0] map_byte(input logic [7:0] b);
    logic [7:0] r;
    if (b >= 8'h61 && b <= 8'h7A) begin
      r = b - 8'h20;
    end else if (b >= 8'h20 && b <= 8'h5F) begin
      r = b;
    end else begin
      r = 8'h3F;
    end
    return r;
  endfunction

  // Handshake decode and byte classification.
  always_comb begin
    accept_c  = rx_valid & rx_ready;
    is_term_c = (rx_data == 8'h0A) || (rx_data == 8'h0D);
    mapped_c  = map_byte(rx_data);
  end

  // Line-assembly FSM: FILL collects bytes, PEND waits for a frame pulse to commit.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state       <= FILL;
      rx_ready    <= 1'b0;
      titles      <= {CHARS{PAD}};
      title_upd   <= 1'b0;
      title_trunc <= 1'b0;
      idx         <= '0;
      trunc_flag  <= 1'b0;
      for (int i = 0; i < int'(CHARS); i++) begin
        shadow[i] <= PAD;
      end
    end else begin
      title_upd <= 1'b0;
      case (state)
        FILL: begin
          rx_ready <= 1'b1;
          if (accept_c) begin
            if (is_term_c) begin
              state    <= PEND;
              rx_ready <= 1'b0;
            end else if (idx < IDX_W'(CHARS)) begin
              for (int i = 0; i < int'(CHARS); i++) begin
                if (idx == IDX_W'(i)) begin
                  shadow[i] <= mapped_c;
                end
              end
              idx <= idx + IDX_W'(1);
            end else begin
              trunc_flag <= 1'b1;
            end
          end
        end
        PEND: begin
          rx_ready <= 1'b0;
          if (frame) begin
            // Commit whole line at once so titles never shows a partial line.
            for (int i = 0; i < int'(CHARS); i++) begin
              titles[8*(int'(CHARS)-1-i) +: 8] <= shadow[i];
              shadow[i] <= PAD;
            end
            title_trunc <= trunc_flag;
            title_upd   <= 1'b1;
            idx         <= '0;
            trunc_flag  <= 1'b0;
            state       <= FILL;
            rx_ready    <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_title_writer.sv
// tb_title_writer: directed vectors with hand-computed expected titles.
module tb_title_writer;

  localparam int unsigned CHARS = 10;
  localparam logic [79:0] ALL_PAD = 80'h20202020202020202020;

  logic              clk_pix = 1'b0;
  logic              rst_pix;
  logic              frame;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [8*CHARS-1:0] titles;
  logic              title_upd;
  logic              title_trunc;

  int n_chk  = 0;
  int n_pass = 0;

  title_writer #(.CHARS(CHARS), .PAD(8'h20)) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .frame       (frame),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .titles      (titles),
    .title_upd   (title_upd),
    .title_trunc (title_trunc)
  );

  always #5 clk_pix = ~clk_pix;

  // Count one comparison and report a mismatch.
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Offer one byte (called at a negedge); optionally pulse frame on the same edge.
  task automatic send_byte(input logic [7:0] b, input logic with_frame);
    int n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk_pix);
      n++;
    end
    if (!rx_ready) chk("rdy_wait", 80'(rx_ready), 80'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    frame    = with_frame;
    @(negedge clk_pix);
    rx_valid = 1'b0;
    frame    = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  // One-cycle frame pulse; returns on the negedge after the commit edge.
  task automatic pulse_frame();
    frame = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
  endtask

  // Pulse frame and check the committed line plus the one-cycle update strobe.
  task automatic commit_check(input string tag, input logic [79:0] exp_t, input logic exp_tr);
    pulse_frame();
    chk({tag, "_upd"},   80'(title_upd), 80'd1);
    chk({tag, "_title"}, titles, exp_t);
    chk({tag, "_trunc"}, 80'(title_trunc), 80'(exp_tr));
    @(negedge clk_pix);
    chk({tag, "_upd0"},  80'(title_upd), 80'd0);
    chk({tag, "_rdy"},   80'(rx_ready), 80'd1);
  endtask

  initial begin
    rst_pix  = 1'b1;
    frame    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_pix);
    chk("rst_titles", titles, ALL_PAD);
    chk("rst_upd",    80'(title_upd), 80'd0);
    chk("rst_trunc",  80'(title_trunc), 80'd0);
    chk("rst_rdy",    80'(rx_ready), 80'd0);
    rst_pix = 1'b0;
    #1 chk("rel_rdy0", 80'(rx_ready), 80'd0);
    @(negedge clk_pix);
    chk("rel_rdy1", 80'(rx_ready), 80'd1);

    // "hello" + LF, frame 100 cycles later
    send_str("hello");
    send_byte(8'h0A, 1'b0);
    chk("hello_rdy_pend", 80'(rx_ready), 80'd0);
    repeat (100) @(negedge clk_pix);
    chk("hello_rdy_wait", 80'(rx_ready), 80'd0);
    chk("hello_no_upd",   80'(title_upd), 80'd0);
    chk("hello_stable",   titles, ALL_PAD);
    commit_check("hello", 80'h48454C4C4F2020202020, 1'b0);

    // Overlong line truncates
    send_str("ABCDEFGHIJKL");
    send_byte(8'h0D, 1'b0);
    repeat (3) @(negedge clk_pix);
    commit_check("trunc", 80'h4142434445464748494A, 1'b1);

    // Non-printables map to '?'
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h0A, 1'b0);
    commit_check("qmark", 80'h3F3F4120202020202020, 1'b0);

    // Classification boundaries: 0x60, 0x7B, 0x5F, 0x7A, 0x1F, 0x20
    send_byte(8'h60, 1'b0);
    send_byte(8'h7B, 1'b0);
    send_byte(8'h5F, 1'b0);
    send_byte(8'h7A, 1'b0);
    send_byte(8'h1F, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h0A, 1'b0);
    commit_check("bounds", 80'h3F3F5F5A3F2020202020, 1'b0);

    // Exactly CHARS bytes: full line, no truncation
    send_str("0123456789");
    send_byte(8'h0A, 1'b0);
    commit_check("full", 80'h30313233343536373839, 1'b0);

    // Empty line commits all PAD
    send_byte(8'h0D, 1'b0);
    commit_check("empty", ALL_PAD, 1'b0);

    // Frame on the same edge as the terminator is ignored
    send_str("Q");
    send_byte(8'h0A, 1'b1);
    chk("same_no_upd",  80'(title_upd), 80'd0);
    chk("same_keep",    titles, ALL_PAD);
    repeat (5) @(negedge clk_pix);
    chk("same_still",   titles, ALL_PAD);
    commit_check("same", 80'h51202020202020202020, 1'b0);

    // Reset mid-line discards the partial line
    send_str("xyz");
    rst_pix = 1'b1;
    @(negedge clk_pix);
    chk("mid_rst_titles", titles, ALL_PAD);
    chk("mid_rst_rdy",    80'(rx_ready), 80'd0);
    rst_pix = 1'b0;
    @(negedge clk_pix);
    send_str("Z");
    send_byte(8'h0A, 1'b0);
    commit_check("mid_rst", 80'h5A202020202020202020, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
